// File: rtl/ext_int_responder.sv
// ---------------------------------------------------------------------------
// ext_int_responder
//
// Processor-side responder for the external interrupt request/acknowledge
// handshake. It qualifies a request against the global enable, waits for an
// instruction boundary, and then takes the trap. Taking the trap emits a
// one-cycle take/ack pulse, selects the vector, saves the PC and bumps the
// serviced count. After the take it watches for the controller to drop its
// request, and it tracks handler residency until return-from-interrupt.
//
// Ports
//   Sys_Clock          in   1   system clock, rising edge
//   Sys_Reset          in   1   asynchronous, active-high reset
//   EIC_IntReq         in   1   request level from the interrupt controller
//   EIC_IntId          in   1   request class (1 = urgent, 0 = normal)
//   EIC_IntAck         out  1   one-cycle acknowledge pulse
//   Cpu_IntEnable      in   1   global enable, gates normal requests only
//   Cpu_InstrBoundary  in   1   pipeline can accept a trap this cycle
//   Cpu_Pc             in   32  PC of the next instruction at the boundary
//   Cpu_IntReturn      in   1   handler executed return-from-interrupt
//   Cpu_TrapTake       out  1   one-cycle fetch redirect pulse
//   Cpu_TrapVector     out  32  trap vector, held until the next take
//   Saved_Pc           out  32  PC captured at the take
//   Int_InService      out  1   handler active
//   Int_AckError       out  1   sticky: request not dropped after ack
//   Int_Count          out  16  serviced-interrupt count, saturating
// ---------------------------------------------------------------------------
module ext_int_responder #(
    parameter logic [31:0] VEC_NORMAL  = 32'h0000_0008,
    parameter logic [31:0] VEC_URGENT  = 32'h0000_000C,
    parameter int unsigned ACK_TIMEOUT = 16
) (
    input  logic        Sys_Clock,
    input  logic        Sys_Reset,
    input  logic        EIC_IntReq,
    input  logic        EIC_IntId,
    output logic        EIC_IntAck,
    input  logic        Cpu_IntEnable,
    input  logic        Cpu_InstrBoundary,
    input  logic [31:0] Cpu_Pc,
    input  logic        Cpu_IntReturn,
    output logic        Cpu_TrapTake,
    output logic [31:0] Cpu_TrapVector,
    output logic [31:0] Saved_Pc,
    output logic        Int_InService,
    output logic        Int_AckError,
    output logic [15:0] Int_Count
);

    localparam int TW = $clog2(ACK_TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_PEND      = 2'd1,
        S_WAIT_DROP = 2'd2,
        S_SERVICE   = 2'd3
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;

    logic            r_cls;        // latched request class, 1 = urgent
    logic [TW-1:0]   r_timer;      // cycles left for the request to drop
    logic            r_rearm_blk;  // stuck request must go low before re-arm

    logic            r_ack;
    logic            r_take;
    logic [31:0]     r_vec;
    logic [31:0]     r_pc;
    logic            r_insvc;
    logic            r_err;
    logic [15:0]     r_cnt;

    logic            w_eligible;
    logic            w_cls_load;
    logic            w_take;
    logic            w_timer_dec;
    logic            w_err_set;
    logic            w_svc_done;

    // Urgent requests bypass the global enable.
    assign w_eligible = EIC_IntReq && (EIC_IntId || Cpu_IntEnable);

    // ------------------------------------------------------------------
    // Next-state and control strobes
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_cls_load  = 1'b0;
        w_take      = 1'b0;
        w_timer_dec = 1'b0;
        w_err_set   = 1'b0;
        w_svc_done  = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (w_eligible && !r_rearm_blk) begin
                    w_cls_load  = 1'b1;
                    w_state_nxt = S_PEND;
                end
            end

            S_PEND: begin
                // A dropped request or a mask on a normal request beats a
                // boundary arriving in the same cycle.
                if (!EIC_IntReq) begin
                    w_state_nxt = S_IDLE;
                end else if (!r_cls && !Cpu_IntEnable) begin
                    w_state_nxt = S_IDLE;
                end else if (Cpu_InstrBoundary) begin
                    w_take      = 1'b1;
                    w_state_nxt = S_WAIT_DROP;
                end
            end

            S_WAIT_DROP: begin
                // The timer still holds its load value at the end of the ack
                // cycle, so the error fires only after ACK_TIMEOUT full
                // cycles beyond it.
                if (!EIC_IntReq) begin
                    w_state_nxt = S_SERVICE;
                end else if (r_timer == '0) begin
                    w_err_set   = 1'b1;
                    w_state_nxt = S_SERVICE;
                end else begin
                    w_timer_dec = 1'b1;
                end
            end

            S_SERVICE: begin
                // No nesting: requests wait here until the handler returns.
                if (Cpu_IntReturn) begin
                    w_svc_done  = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end

            default: w_state_nxt = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge Sys_Clock or posedge Sys_Reset) begin
        if (Sys_Reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Class latch, drop timer and re-arm guard
    // ------------------------------------------------------------------
    always_ff @(posedge Sys_Clock or posedge Sys_Reset) begin
        if (Sys_Reset) begin
            r_cls       <= 1'b0;
            r_timer     <= '0;
            r_rearm_blk <= 1'b0;
        end else begin
            if (w_cls_load) begin
                r_cls <= EIC_IntId;
            end

            if (w_take) begin
                r_timer <= TW'(ACK_TIMEOUT);
            end else if (w_timer_dec) begin
                r_timer <= r_timer - 1'b1;
            end

            // Set only while the request is still high, so the two arms
            // never compete.
            if (w_err_set) begin
                r_rearm_blk <= 1'b1;
            end else if (!EIC_IntReq) begin
                r_rearm_blk <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge Sys_Clock or posedge Sys_Reset) begin
        if (Sys_Reset) begin
            r_ack   <= 1'b0;
            r_take  <= 1'b0;
            r_vec   <= '0;
            r_pc    <= '0;
            r_insvc <= 1'b0;
            r_err   <= 1'b0;
            r_cnt   <= '0;
        end else begin
            // Ack and take are single-cycle strobes from the take edge.
            r_ack  <= w_take;
            r_take <= w_take;

            if (w_take) begin
                r_vec <= r_cls ? VEC_URGENT : VEC_NORMAL;
                r_pc  <= Cpu_Pc;
                if (r_cnt != 16'hFFFF) begin
                    r_cnt <= r_cnt + 16'd1;
                end
            end

            if (w_take) begin
                r_insvc <= 1'b1;
            end else if (w_svc_done) begin
                r_insvc <= 1'b0;
            end

            if (w_err_set) begin
                r_err <= 1'b1;
            end
        end
    end

    assign EIC_IntAck     = r_ack;
    assign Cpu_TrapTake   = r_take;
    assign Cpu_TrapVector = r_vec;
    assign Saved_Pc       = r_pc;
    assign Int_InService  = r_insvc;
    assign Int_AckError   = r_err;
    assign Int_Count      = r_cnt;

endmodule

// File: tb/tb_ext_int_responder.sv
// ---------------------------------------------------------------------------
// tb_ext_int_responder
//
// Directed scenarios followed by randomized controller/CPU traffic. A
// behavioural model tracks the handshake in terms of "phase" and "cycles
// since take", and a negedge compare process checks every output against it
// each cycle. Directed scenarios add literal expectations.
// ---------------------------------------------------------------------------
module tb_ext_int_responder;

    localparam int ACK_TO = 16;

    logic        Sys_Clock;
    logic        Sys_Reset;
    logic        EIC_IntReq;
    logic        EIC_IntId;
    logic        EIC_IntAck;
    logic        Cpu_IntEnable;
    logic        Cpu_InstrBoundary;
    logic [31:0] Cpu_Pc;
    logic        Cpu_IntReturn;
    logic        Cpu_TrapTake;
    logic [31:0] Cpu_TrapVector;
    logic [31:0] Saved_Pc;
    logic        Int_InService;
    logic        Int_AckError;
    logic [15:0] Int_Count;

    ext_int_responder dut (
        .Sys_Clock         (Sys_Clock),
        .Sys_Reset         (Sys_Reset),
        .EIC_IntReq        (EIC_IntReq),
        .EIC_IntId         (EIC_IntId),
        .EIC_IntAck        (EIC_IntAck),
        .Cpu_IntEnable     (Cpu_IntEnable),
        .Cpu_InstrBoundary (Cpu_InstrBoundary),
        .Cpu_Pc            (Cpu_Pc),
        .Cpu_IntReturn     (Cpu_IntReturn),
        .Cpu_TrapTake      (Cpu_TrapTake),
        .Cpu_TrapVector    (Cpu_TrapVector),
        .Saved_Pc          (Saved_Pc),
        .Int_InService     (Int_InService),
        .Int_AckError      (Int_AckError),
        .Int_Count         (Int_Count)
    );

    initial Sys_Clock = 1'b0;
    always #5 Sys_Clock = ~Sys_Clock;

    int n_pass  = 0;
    int n_total = 0;
    bit chk_en  = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // ---------------- behavioural model ----------------
    // phase: 0 idle, 1 waiting for boundary, 2 waiting for drop, 3 handler
    int          m_phase;
    bit          m_cls;
    bit          m_need_low;
    int          m_age;
    logic        exp_ack, exp_take, exp_insvc, exp_err;
    logic [31:0] exp_vec, exp_pc;
    logic [15:0] exp_cnt;

    task automatic model_reset();
        m_phase = 0; m_cls = 0; m_need_low = 0; m_age = 0;
        exp_ack = 0; exp_take = 0; exp_insvc = 0; exp_err = 0;
        exp_vec = 0; exp_pc = 0; exp_cnt = 0;
    endtask

    // Called once per rising edge with the inputs sampled at that edge.
    task automatic model_step();
        if (Sys_Reset) begin
            model_reset();
            return;
        end
        exp_ack  = 0;
        exp_take = 0;
        case (m_phase)
            0: if (EIC_IntReq && (EIC_IntId || Cpu_IntEnable) && !m_need_low) begin
                   m_phase = 1;
                   m_cls   = EIC_IntId;
               end
            1: if (!EIC_IntReq || (!m_cls && !Cpu_IntEnable)) begin
                   m_phase = 0;
               end else if (Cpu_InstrBoundary) begin
                   exp_ack   = 1;
                   exp_take  = 1;
                   exp_vec   = m_cls ? 32'h0000_000C : 32'h0000_0008;
                   exp_pc    = Cpu_Pc;
                   exp_cnt   = (exp_cnt == 16'hFFFF) ? exp_cnt : exp_cnt + 16'd1;
                   exp_insvc = 1;
                   m_age     = 0;
                   m_phase   = 2;
               end
            2: begin
                   m_age++;
                   if (!EIC_IntReq) m_phase = 3;
                   else if (m_age > ACK_TO) begin
                       exp_err    = 1;
                       m_need_low = 1;
                       m_phase    = 3;
                   end
               end
            default: if (Cpu_IntReturn) begin
                   exp_insvc = 0;
                   m_phase   = 0;
               end
        endcase
        if (!EIC_IntReq) m_need_low = 0;
    endtask

    // ---------------- per-cycle compare ----------------
    always @(negedge Sys_Clock) begin
        if (chk_en) begin
            chk("ack",    EIC_IntAck,     exp_ack);
            chk("take",   Cpu_TrapTake,   exp_take);
            chk("vector", Cpu_TrapVector, exp_vec);
            chk("savepc", Saved_Pc,       exp_pc);
            chk("insvc",  Int_InService,  exp_insvc);
            chk("ackerr", Int_AckError,   exp_err);
            chk("count",  Int_Count,      exp_cnt);
        end
    end

    // Advance n edges; returns 1 ns after the last edge.
    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge Sys_Clock);
            model_step();
            #1;
        end
    endtask

    task automatic ret_pulse();
        Cpu_IntReturn = 1; cyc(1); Cpu_IntReturn = 0;
    endtask

    task automatic idle_inputs();
        EIC_IntReq = 0; EIC_IntId = 0; Cpu_IntEnable = 0;
        Cpu_InstrBoundary = 0; Cpu_Pc = 0; Cpu_IntReturn = 0;
    endtask

    initial begin
        int cnt;
        int hold;
        bit acked;

        idle_inputs();
        Sys_Reset = 1;
        model_reset();
        chk_en = 1;
        cyc(2);
        chk("rst_count", Int_Count, 0);
        chk("rst_vec", Cpu_TrapVector, 0);
        Sys_Reset = 0;
        cyc(1);

        // 1: normal, enable=1, boundary held
        Cpu_Pc = 32'h1000_0040; Cpu_IntEnable = 1; Cpu_InstrBoundary = 1;
        EIC_IntId = 0; EIC_IntReq = 1;
        cyc(1);
        chk("s1_take_early", Cpu_TrapTake, 0);
        cyc(1);
        chk("s1_take", Cpu_TrapTake, 1);
        chk("s1_ack", EIC_IntAck, 1);
        chk("s1_vec", Cpu_TrapVector, 32'h8);
        chk("s1_pc", Saved_Pc, 32'h1000_0040);
        chk("s1_cnt", Int_Count, 1);
        chk("s1_model_vec", exp_vec, 32'h8);
        EIC_IntReq = 0;
        cyc(1);
        chk("s1_take_width", Cpu_TrapTake, 0);
        chk("s1_insvc", Int_InService, 1);
        cyc(2);
        ret_pulse();
        chk("s1_ret", Int_InService, 0);

        // 2: urgent with enable=0 and delayed boundary
        Cpu_IntEnable = 0; Cpu_InstrBoundary = 0; EIC_IntId = 1; EIC_IntReq = 1;
        cyc(5);
        chk("s2_wait", Cpu_TrapTake, 0);
        Cpu_Pc = 32'h2000_0100; Cpu_InstrBoundary = 1;
        cyc(1);
        chk("s2_take", Cpu_TrapTake, 1);
        chk("s2_vec", Cpu_TrapVector, 32'hC);
        chk("s2_pc", Saved_Pc, 32'h2000_0100);
        EIC_IntReq = 0; Cpu_InstrBoundary = 0;
        cyc(2);
        ret_pulse();
        // normal with enable=0 must never be acked
        EIC_IntId = 0; EIC_IntReq = 1; Cpu_InstrBoundary = 1;
        cnt = 0;
        repeat (100) begin cyc(1); if (EIC_IntAck) cnt++; end
        chk("s2_masked_acks", cnt, 0);
        EIC_IntReq = 0;
        cyc(1);

        // 3: enable drops while pending, later re-enabled
        Cpu_IntEnable = 1; Cpu_InstrBoundary = 0; EIC_IntId = 0; EIC_IntReq = 1;
        cyc(1);
        Cpu_IntEnable = 0;
        cyc(4);
        chk("s3_masked", Cpu_TrapTake, 0);
        Cpu_IntEnable = 1; Cpu_InstrBoundary = 1;
        cyc(2);
        chk("s3_take", Cpu_TrapTake, 1);
        chk("s3_vec", Cpu_TrapVector, 32'h8);
        EIC_IntReq = 0;
        cyc(2);
        ret_pulse();

        // 4: request stuck high after ack
        EIC_IntId = 1; EIC_IntReq = 1; Cpu_InstrBoundary = 1;
        cyc(2);
        chk("s4_take", Cpu_TrapTake, 1);
        cyc(ACK_TO);
        chk("s4_err_early", Int_AckError, 0);
        cyc(1);
        chk("s4_err", Int_AckError, 1);
        ret_pulse();
        cnt = 0;
        repeat (10) begin cyc(1); if (Cpu_TrapTake) cnt++; end
        chk("s4_no_retake", cnt, 0);
        EIC_IntReq = 0;
        cyc(1);
        EIC_IntReq = 1;
        cyc(2);
        chk("s4_retake", Cpu_TrapTake, 1);
        EIC_IntReq = 0;
        cyc(2);
        ret_pulse();

        // 5: second request during service, fresh reset
        idle_inputs();
        Sys_Reset = 1; model_reset();
        cyc(2);
        Sys_Reset = 0;
        Cpu_IntEnable = 1; Cpu_InstrBoundary = 1; EIC_IntReq = 1;
        cyc(2);
        EIC_IntReq = 0;
        cyc(2);
        EIC_IntReq = 1;
        cnt = 0;
        repeat (5) begin cyc(1); if (Cpu_TrapTake) cnt++; end
        chk("s5_ignored", cnt, 0);
        ret_pulse();
        cyc(1);
        chk("s5_no_same_edge", Cpu_TrapTake, 0);
        cyc(1);
        chk("s5_take", Cpu_TrapTake, 1);
        chk("s5_cnt", Int_Count, 2);
        EIC_IntReq = 0;
        cyc(2);
        ret_pulse();

        // 6: reset in pending, then in wait-for-drop
        Cpu_InstrBoundary = 0; EIC_IntReq = 1;
        cyc(1);
        #1 Sys_Reset = 1; model_reset();
        #1;
        chk("s6_pend_ack", EIC_IntAck, 0);
        chk("s6_pend_cnt", Int_Count, 0);
        cyc(1);
        Sys_Reset = 0; Cpu_InstrBoundary = 1;
        cyc(2);
        chk("s6_ack_pre", EIC_IntAck, 1);
        #1 Sys_Reset = 1; model_reset();
        #1;
        chk("s6_wd_ack", EIC_IntAck, 0);
        chk("s6_wd_take", Cpu_TrapTake, 0);
        chk("s6_wd_insvc", Int_InService, 0);
        chk("s6_wd_pc", Saved_Pc, 0);
        chk("s6_wd_vec", Cpu_TrapVector, 0);
        EIC_IntReq = 0;
        cyc(2);
        Sys_Reset = 0;

        // Random traffic with a mostly well-behaved controller.
        idle_inputs();
        hold = 0; acked = 0;
        repeat (4000) begin
            if (!EIC_IntReq) begin
                if ($urandom_range(3) == 0) begin
                    EIC_IntReq = 1;
                    EIC_IntId  = 1'($urandom_range(1));
                    acked = 0;
                    hold  = ($urandom_range(7) == 0) ? 25 : int'($urandom_range(3));
                end
            end else begin
                if (exp_ack) acked = 1;
                if (acked) begin
                    if (hold == 0) EIC_IntReq = 0;
                    else hold--;
                end else if ($urandom_range(31) == 0) begin
                    EIC_IntReq = 0;
                end
            end
            if ($urandom_range(7) == 0) Cpu_IntEnable = ~Cpu_IntEnable;
            Cpu_InstrBoundary = 1'($urandom_range(1));
            Cpu_IntReturn     = ($urandom_range(5) == 0);
            Cpu_Pc            = $urandom;
            cyc(1);
        end

        chk_en = 0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
